// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer and the byte engine it drives:
// engine command codes, response error codes and sequencer states.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } eng_cmd_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_ADDR_NACK = 2'b01,
        ERR_DATA_NACK = 2'b10,
        ERR_TIMEOUT   = 2'b11
    } rsp_err_t;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_ARB  = 4'd1,
        S_ADDR  = 4'd2,
        S_REG   = 4'd3,
        S_DATA  = 4'd4,
        S_RADDR = 4'd5,
        S_READ  = 4'd6,
        S_STOP  = 4'd7,
        S_DONE  = 4'd8
    } seq_state_t;

    // States that hand one command to the engine and then wait for its completion
    function automatic logic is_issue_state(input seq_state_t s);
        case (s)
            S_ADDR, S_REG, S_DATA, S_RADDR, S_READ, S_STOP: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_rr_arb.sv
// Round-robin pick: first valid requester at or after the pointer, as onehot and index.
module i2c_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    localparam int SW = IDX_W + 1;

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [SW-1:0]      sum_s;
    logic               found_s;

    // Rotate so the pointer lands at bit 0, then take the lowest set bit
    always_comb begin
        dbl_s   = {valid, valid};
        rot_s   = N_REQ'(dbl_s >> ptr);
        found_s = 1'b0;
        sum_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                sum_s   = SW'(ptr) + SW'(k);
            end else begin
                found_s = found_s;
            end
        end
        if (sum_s >= SW'(N_REQ)) begin
            sum_s = sum_s - SW'(N_REQ);
        end else begin
            sum_s = sum_s;
        end
        index = sum_s[IDX_W-1:0];
        any   = found_s;
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found_s && (sum_s[IDX_W-1:0] == IDX_W'(i));
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction controller: arbitrates requesters, expands each
// request into engine byte commands, returns status/read data, and guards the engine.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_dev,
    input  logic [8*N_REQ-1:0] req_reg,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_done,
    output logic [7:0]         rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic               eng_go,
    output logic [1:0]         eng_cmd,
    output logic [7:0]         eng_wdata,
    output logic               eng_abort,
    input  logic               eng_done,
    input  logic               eng_nack,
    input  logic [7:0]         eng_rdata,
    output logic               busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW    = IDX_W + 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    seq_state_t       state_r, next_s;
    rsp_err_t         err_r, err_nxt_s, rsp_err_r;
    eng_cmd_t         eng_cmd_r, cmd_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r, ptr_nxt_s, arb_idx_s;
    logic [PW-1:0]    ptr_sum_s;
    logic [N_REQ-1:0] arb_grant_s, grant_oh_r, req_done_r;
    logic             arb_any_s;
    logic             sel_rw_s, rw_r;
    logic [6:0]       sel_dev_s, dev_r;
    logic [7:0]       sel_reg_s, sel_wdata_s, reg_r, wdata_r, rd_r;
    logic [7:0]       wdata_nxt_s, eng_wdata_r, rsp_rdata_r;
    logic [TW-1:0]    timer_r;
    logic             wait_s, done_s, expire_s, go_nxt_s, enter_done_s;
    logic             eng_go_r, eng_abort_r, busy_r;

    i2c_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .index (arb_idx_s),
        .any   (arb_any_s)
    );

    // Fields of the requester the arbiter is currently pointing at, and the pointer after it
    always_comb begin
        sel_rw_s    = 1'b0;
        sel_dev_s   = 7'h00;
        sel_reg_s   = 8'h00;
        sel_wdata_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            sel_rw_s    = (arb_idx_s == IDX_W'(i)) ? req_rw[i]           : sel_rw_s;
            sel_dev_s   = (arb_idx_s == IDX_W'(i)) ? req_dev[i*7 +: 7]   : sel_dev_s;
            sel_reg_s   = (arb_idx_s == IDX_W'(i)) ? req_reg[i*8 +: 8]   : sel_reg_s;
            sel_wdata_s = (arb_idx_s == IDX_W'(i)) ? req_wdata[i*8 +: 8] : sel_wdata_s;
        end
        ptr_sum_s = PW'(arb_idx_s) + PW'(1);
        ptr_nxt_s = (ptr_sum_s >= PW'(N_REQ)) ? '0 : ptr_sum_s[IDX_W-1:0];
    end

    // Next-state logic; the cycle carrying eng_go is not a wait cycle
    always_comb begin
        next_s    = state_r;
        err_nxt_s = err_r;
        wait_s    = is_issue_state(state_r) && !eng_go_r;
        done_s    = wait_s && eng_done;
        expire_s  = wait_s && !eng_done && (timer_r >= TW'(TIMEOUT_CYC));
        case (state_r)
            ST_IDLE: next_s = (|req_valid) ? ST_ARB : ST_IDLE;
            ST_ARB: begin
                next_s    = arb_any_s ? S_ADDR : ST_IDLE;
                err_nxt_s = ERR_OK;
            end
            S_ADDR, S_RADDR: begin
                if (done_s && eng_nack) begin
                    err_nxt_s = ERR_ADDR_NACK;
                    next_s    = S_STOP;
                end else if (done_s) begin
                    next_s = (state_r == S_ADDR) ? S_REG : S_READ;
                end else begin
                    next_s = state_r;
                end
            end
            S_REG: begin
                if (done_s && eng_nack) begin
                    err_nxt_s = ERR_DATA_NACK;
                    next_s    = S_STOP;
                end else if (done_s) begin
                    next_s = rw_r ? S_RADDR : S_DATA;
                end else begin
                    next_s = S_REG;
                end
            end
            S_DATA: begin
                err_nxt_s = (done_s && eng_nack) ? ERR_DATA_NACK : err_r;
                next_s    = done_s ? S_STOP : S_DATA;
            end
            S_READ:  next_s = done_s ? S_STOP : S_READ;
            S_STOP:  next_s = done_s ? S_DONE : S_STOP;
            S_DONE:  next_s = ST_IDLE;
            default: begin
                next_s    = ST_IDLE;
                err_nxt_s = ERR_OK;
            end
        endcase
        // Watchdog expiry skips STOP: the abort already releases the bus
        if (expire_s) begin
            next_s    = S_DONE;
            err_nxt_s = ERR_TIMEOUT;
        end else begin
            err_nxt_s = err_nxt_s;
        end
    end

    // Command and byte to present when entering an issue state
    always_comb begin
        go_nxt_s     = is_issue_state(next_s) && (next_s != state_r);
        enter_done_s = (next_s == S_DONE) && (state_r != S_DONE);
        cmd_nxt_s    = CMD_STOP;
        wdata_nxt_s  = 8'h00;
        case (next_s)
            S_ADDR: begin
                cmd_nxt_s   = CMD_START;
                wdata_nxt_s = {sel_dev_s, 1'b0};
            end
            S_REG: begin
                cmd_nxt_s   = CMD_WRITE;
                wdata_nxt_s = reg_r;
            end
            S_DATA: begin
                cmd_nxt_s   = CMD_WRITE;
                wdata_nxt_s = wdata_r;
            end
            S_RADDR: begin
                cmd_nxt_s   = CMD_START;
                wdata_nxt_s = {dev_r, 1'b1};
            end
            S_READ:  cmd_nxt_s = CMD_READ;
            default: cmd_nxt_s = CMD_STOP;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Transaction context: latched winner, round-robin pointer, status, watchdog timer
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_ptr_r   <= '0;
            grant_oh_r <= '0;
            rw_r       <= 1'b0;
            dev_r      <= 7'h00;
            reg_r      <= 8'h00;
            wdata_r    <= 8'h00;
            rd_r       <= 8'h00;
            err_r      <= ERR_OK;
            timer_r    <= '0;
        end else begin
            if (state_r == ST_ARB && arb_any_s) begin
                rr_ptr_r   <= ptr_nxt_s;
                grant_oh_r <= arb_grant_s;
                rw_r       <= sel_rw_s;
                dev_r      <= sel_dev_s;
                reg_r      <= sel_reg_s;
                wdata_r    <= sel_wdata_s;
                rd_r       <= 8'h00;
            end else if (state_r == S_READ && done_s) begin
                rd_r <= eng_rdata;
            end else begin
                rd_r <= rd_r;
            end
            err_r <= err_nxt_s;
            if (go_nxt_s) begin
                timer_r <= '0;
            end else if (is_issue_state(state_r)) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Registered outputs to the engine and to the requesters
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            eng_go_r    <= 1'b0;
            eng_cmd_r   <= CMD_START;
            eng_wdata_r <= 8'h00;
            eng_abort_r <= 1'b0;
            req_done_r  <= '0;
            rsp_err_r   <= ERR_OK;
            rsp_rdata_r <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            eng_go_r    <= go_nxt_s;
            eng_abort_r <= expire_s;
            busy_r      <= (next_s != ST_IDLE);
            req_done_r  <= enter_done_s ? grant_oh_r : '0;
            if (go_nxt_s) begin
                eng_cmd_r   <= cmd_nxt_s;
                eng_wdata_r <= wdata_nxt_s;
            end else begin
                eng_cmd_r   <= eng_cmd_r;
                eng_wdata_r <= eng_wdata_r;
            end
            if (enter_done_s) begin
                rsp_err_r <= err_nxt_s;
            end else begin
                rsp_err_r <= rsp_err_r;
            end
            if (enter_done_s && rw_r && err_nxt_s == ERR_OK) begin
                rsp_rdata_r <= rd_r;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign eng_go    = eng_go_r;
    assign eng_cmd   = eng_cmd_r;
    assign eng_wdata = eng_wdata_r;
    assign eng_abort = eng_abort_r;
    assign req_done  = req_done_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural byte-engine responder.
module tb_i2c_txn_sequencer;

    localparam int N_REQ = 2;
    localparam int TO    = 4095;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ-1:0]   req_rw = '0;
    logic [7*N_REQ-1:0] req_dev = '0;
    logic [8*N_REQ-1:0] req_reg = '0;
    logic [8*N_REQ-1:0] req_wdata = '0;
    logic [N_REQ-1:0]   req_done;
    logic [7:0]         rsp_rdata;
    logic [1:0]         rsp_err;
    logic               eng_go;
    logic [1:0]         eng_cmd;
    logic [7:0]         eng_wdata;
    logic               eng_abort;
    logic               eng_done = 1'b0;
    logic               eng_nack = 1'b0;
    logic [7:0]         eng_rdata = 8'h00;
    logic               busy;

    i2c_txn_sequencer #(.N_REQ(N_REQ), .TIMEOUT_CYC(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eng_go(eng_go), .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
        .eng_abort(eng_abort), .eng_done(eng_done), .eng_nack(eng_nack),
        .eng_rdata(eng_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [9:0] cmd_log[$];
    int go_cyc[$];
    logic [N_REQ-1:0] dn_grant[$];
    logic [1:0] dn_err[$];
    int done_cnt = 0;
    int done_limit = 0;
    int abort_cnt = 0;
    int abort_cyc = 0;
    int nack_at = -1;
    int hang_at = -1;
    int slow_at = -1;
    int slow_lat = 2;
    logic [7:0] rd_val = 8'h00;

    initial forever #5 Clk = ~Clk;
    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Byte engine model: logs each command, answers after a latency, may NACK or hang
    initial begin
        int cnt;
        int idx;
        bit pend;
        cnt = 0; idx = 0; pend = 1'b0;
        forever begin
            @(negedge Clk);
            eng_done = 1'b0;
            eng_nack = 1'b0;
            if (!Rst_n || eng_abort) begin
                pend = 1'b0;
            end else if (eng_go) begin
                idx = cmd_log.size();
                cmd_log.push_back({eng_cmd, eng_wdata});
                go_cyc.push_back(cyc);
                pend = (idx != hang_at);
                cnt = (idx == slow_at) ? slow_lat : 2;
            end else if (pend) begin
                if (cnt > 1) begin
                    cnt--;
                end else begin
                    eng_done = 1'b1;
                    eng_nack = (idx == nack_at);
                    eng_rdata = rd_val;
                    pend = 1'b0;
                end
            end
        end
    end

    // Requester side: record completions, release requests once enough are served
    initial forever begin
        @(negedge Clk);
        if (Rst_n) begin
            if (|req_done) begin
                dn_grant.push_back(req_done);
                dn_err.push_back(rsp_err);
                done_cnt++;
                if (done_cnt >= done_limit) req_valid = '0;
            end
            if (eng_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "global timeout");
    end

    function automatic logic [9:0] log_at(input int k);
        return (k < cmd_log.size()) ? cmd_log[k] : 10'h3FF;
    endfunction

    function automatic logic [N_REQ-1:0] grant_at(input int k);
        return (k < dn_grant.size()) ? dn_grant[k] : '1;
    endfunction

    function automatic logic [1:0] err_at(input int k);
        return (k < dn_err.size()) ? dn_err[k] : 2'bxx;
    endfunction

    task automatic clear_logs();
        cmd_log.delete(); go_cyc.delete(); dn_grant.delete(); dn_err.delete();
        abort_cnt = 0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_rw[i] = rw;
        req_dev[i*7 +: 7] = dev;
        req_reg[i*8 +: 8] = rg;
        req_wdata[i*8 +: 8] = wd;
    endtask

    task automatic wait_dones(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge Clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (eng_go !== 1'b0 || eng_abort !== 1'b0) $display("FAIL rst_eng: got go=%b abort=%b expected 0", eng_go, eng_abort); else n_pass++;
        n_checks++; if (req_done !== 2'b00 || rsp_err !== 2'b00) $display("FAIL rst_rsp: got done=%b err=%b expected 0", req_done, rsp_err); else n_pass++;
        n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", rsp_rdata); else n_pass++;
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        bit ok;
        logic [9:0] e;
        clear_logs();
        set_req(0, 1'b0, 7'h20, 8'h06, 8'hA5);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        wait_dones(done_limit, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL wr_wait: got no req_done expected one"); else n_pass++;
        n_checks++; if (cmd_log.size() != 4) $display("FAIL wr_ncmd: got %0d expected 4", cmd_log.size()); else n_pass++;
        n_checks++; if (log_at(0) !== 10'h040) $display("FAIL wr_start: got %h expected 040", log_at(0)); else n_pass++;
        n_checks++; if (log_at(1) !== 10'h106) $display("FAIL wr_reg: got %h expected 106", log_at(1)); else n_pass++;
        n_checks++; if (log_at(2) !== 10'h1A5) $display("FAIL wr_data: got %h expected 1A5", log_at(2)); else n_pass++;
        e = log_at(3);
        n_checks++; if (e[9:8] !== 2'd3) $display("FAIL wr_stop: got cmd %0d expected 3", e[9:8]); else n_pass++;
        n_checks++; if (grant_at(0) !== 2'b01 || err_at(0) !== 2'b00) $display("FAIL wr_done: got done=%b err=%b expected 01/00", grant_at(0), err_at(0)); else n_pass++;
        n_checks++; if (abort_cnt != 0 || busy !== 1'b0) $display("FAIL wr_after: got aborts=%0d busy=%b expected 0/0", abort_cnt, busy); else n_pass++;
    endtask

    task automatic test_addr_nack();
        bit ok;
        logic [9:0] e;
        clear_logs();
        nack_at = 0;
        set_req(0, 1'b0, 7'h20, 8'h06, 8'hA5);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        wait_dones(done_limit, ok);
        nack_at = -1;
        n_checks++; if (ok !== 1'b1) $display("FAIL an_wait: got no req_done expected one"); else n_pass++;
        e = log_at(1);
        n_checks++; if (cmd_log.size() != 2 || e[9:8] !== 2'd3) $display("FAIL an_cmds: got n=%0d second=%h expected 2 cmds, STOP second", cmd_log.size(), e); else n_pass++;
        n_checks++; if (grant_at(0) !== 2'b01 || err_at(0) !== 2'b01) $display("FAIL an_done: got done=%b err=%b expected 01/01", grant_at(0), err_at(0)); else n_pass++;
    endtask

    task automatic test_data_nack();
        bit ok;
        logic [9:0] e;
        clear_logs();
        nack_at = 2;
        set_req(0, 1'b0, 7'h20, 8'h07, 8'h5A);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        wait_dones(done_limit, ok);
        nack_at = -1;
        e = log_at(3);
        n_checks++; if (cmd_log.size() != 4 || e[9:8] !== 2'd3) $display("FAIL dn_cmds: got n=%0d last=%h expected 4 cmds ending STOP", cmd_log.size(), e); else n_pass++;
        n_checks++; if (ok !== 1'b1 || err_at(0) !== 2'b10) $display("FAIL dn_err: got ok=%b err=%b expected 1/10", ok, err_at(0)); else n_pass++;
    endtask

    task automatic test_read();
        bit ok;
        logic [9:0] e3, e4;
        clear_logs();
        rd_val = 8'h3C;
        set_req(1, 1'b1, 7'h21, 8'h01, 8'h00);
        done_limit = done_cnt + 1;
        req_valid[1] = 1'b1;
        wait_dones(done_limit, ok);
        n_checks++; if (ok !== 1'b1 || cmd_log.size() != 5) $display("FAIL rd_ncmd: got ok=%b n=%0d expected 1/5", ok, cmd_log.size()); else n_pass++;
        n_checks++; if (log_at(0) !== 10'h042) $display("FAIL rd_start: got %h expected 042", log_at(0)); else n_pass++;
        n_checks++; if (log_at(1) !== 10'h101) $display("FAIL rd_reg: got %h expected 101", log_at(1)); else n_pass++;
        n_checks++; if (log_at(2) !== 10'h043) $display("FAIL rd_restart: got %h expected 043", log_at(2)); else n_pass++;
        e3 = log_at(3); e4 = log_at(4);
        n_checks++; if (e3[9:8] !== 2'd2 || e4[9:8] !== 2'd3) $display("FAIL rd_tail: got %h %h expected READ then STOP", e3, e4); else n_pass++;
        n_checks++; if (grant_at(0) !== 2'b10 || err_at(0) !== 2'b00) $display("FAIL rd_done: got done=%b err=%b expected 10/00", grant_at(0), err_at(0)); else n_pass++;
        n_checks++; if (rsp_rdata !== 8'h3C) $display("FAIL rd_data: got %h expected 3C", rsp_rdata); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [N_REQ-1:0] eg;
        logic [9:0] es;
        clear_logs();
        set_req(0, 1'b0, 7'h10, 8'h00, 8'h11);
        set_req(1, 1'b0, 7'h11, 8'h00, 8'h22);
        done_limit = done_cnt + 6;
        req_valid = 2'b11;
        wait_dones(done_limit, ok);
        n_checks++; if (ok !== 1'b1 || dn_grant.size() != 6) $display("FAIL rr_count: got ok=%b n=%0d expected 1/6", ok, dn_grant.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            es = (k % 2 == 0) ? 10'h020 : 10'h022;
            n_checks++; if (grant_at(k) !== eg) $display("FAIL rr_grant%0d: got %b expected %b", k, grant_at(k), eg); else n_pass++;
            n_checks++; if (log_at(4*k) !== es) $display("FAIL rr_start%0d: got %h expected %h", k, log_at(4*k), es); else n_pass++;
        end
        n_checks++; if (rsp_rdata !== 8'h3C) $display("FAIL rr_rdata_hold: got %h expected 3C", rsp_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int gap;
        clear_logs();
        hang_at = 1;
        set_req(0, 1'b0, 7'h20, 8'h06, 8'hA5);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        wait_dones(done_limit, ok);
        hang_at = -1;
        gap = (go_cyc.size() > 1) ? abort_cyc - go_cyc[1] : -1;
        n_checks++; if (ok !== 1'b1 || err_at(0) !== 2'b11) $display("FAIL to_err: got ok=%b err=%b expected 1/11", ok, err_at(0)); else n_pass++;
        n_checks++; if (cmd_log.size() != 2) $display("FAIL to_nostop: got %0d cmds expected 2", cmd_log.size()); else n_pass++;
        n_checks++; if (abort_cnt != 1) $display("FAIL to_abort: got %0d aborts expected 1", abort_cnt); else n_pass++;
        n_checks++; if (gap != TO + 1) $display("FAIL to_gap: got %0d cycles expected %0d", gap, TO + 1); else n_pass++;
    endtask

    task automatic test_done_at_expiry();
        bit ok;
        clear_logs();
        slow_at = 1;
        slow_lat = TO;
        set_req(0, 1'b0, 7'h20, 8'h06, 8'hA5);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        wait_dones(done_limit, ok);
        slow_at = -1;
        n_checks++; if (ok !== 1'b1 || err_at(0) !== 2'b00) $display("FAIL edge_err: got ok=%b err=%b expected 1/00", ok, err_at(0)); else n_pass++;
        n_checks++; if (abort_cnt != 0 || cmd_log.size() != 4) $display("FAIL edge_seq: got aborts=%0d n=%0d expected 0/4", abort_cnt, cmd_log.size()); else n_pass++;
    endtask

    task automatic test_reset_midtxn();
        bit ok;
        clear_logs();
        slow_at = 1;
        slow_lat = 50;
        set_req(0, 1'b0, 7'h20, 8'h06, 8'hA5);
        done_limit = done_cnt + 1;
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            if (cmd_log.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge Clk);
        n_checks++; if (ok !== 1'b1 || busy !== 1'b1) $display("FAIL mr_pre: got reached=%b busy=%b expected 1/1", ok, busy); else n_pass++;
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || eng_go !== 1'b0 || req_done !== 2'b00) $display("FAIL mr_async: got busy=%b go=%b done=%b expected 0", busy, eng_go, req_done); else n_pass++;
        repeat (2) @(negedge Clk);
        slow_at = -1;
        clear_logs();
        set_req(1, 1'b0, 7'h30, 8'h09, 8'h77);
        req_valid = 2'b11;
        done_limit = done_cnt + 1;
        Rst_n = 1'b1;
        wait_dones(done_limit, ok);
        n_checks++; if (ok !== 1'b1 || grant_at(0) !== 2'b01) $display("FAIL mr_regrant: got ok=%b done=%b expected 1/01", ok, grant_at(0)); else n_pass++;
        n_checks++; if (log_at(0) !== 10'h040) $display("FAIL mr_start: got %h expected 040", log_at(0)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_data_nack();
        test_read();
        test_round_robin();
        test_timeout();
        test_done_at_expiry();
        test_reset_midtxn();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
